// File: rtl/core_pkg.sv
// Shared core-wide constants and types used by the decode-stage scoreboard.
package core_pkg;

   localparam int NREG_DEF  = 32;
   localparam int LAT_W_DEF = 3;

   typedef logic [$clog2(NREG_DEF)-1:0] reg_idx_t;

endpackage : core_pkg

// File: rtl/sb_entry.sv
// One scoreboard entry: pending flag plus remaining-latency counter for a
// single architectural register.
module sb_entry
   import core_pkg::*;
#(
   parameter int LAT_W = LAT_W_DEF
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             i_flush,
   input  logic             i_load,
   input  logic [LAT_W-1:0] i_lat,
   input  logic             i_wb_hit,
   output logic             o_pend,
   output logic             o_pend_nxt,
   output logic [LAT_W-1:0] o_cnt
);

   logic             r_pend;
   logic [LAT_W-1:0] r_cnt;
   logic             w_pend_nxt;
   logic [LAT_W-1:0] w_cnt_nxt;

   // Next state: flush beats a new producer, a new producer beats write-back,
   // otherwise count down towards zero and stop there.
   always_comb begin
      w_pend_nxt = r_pend;
      w_cnt_nxt  = r_cnt;
      if (i_flush) begin
         w_pend_nxt = 1'b0;
         w_cnt_nxt  = '0;
      end else if (i_load) begin
         w_pend_nxt = 1'b1;
         w_cnt_nxt  = i_lat;
      end else if (i_wb_hit) begin
         w_pend_nxt = 1'b0;
         w_cnt_nxt  = '0;
      end else if (r_cnt != '0) begin
         w_cnt_nxt = r_cnt - LAT_W'(1);
      end
   end

   // Entry state register.
   // NOTE: state uses non-blocking assignments so every entry samples the
   // same pre-edge values regardless of evaluation order.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_pend <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign o_pend     = r_pend;
   assign o_pend_nxt = w_pend_nxt;
   assign o_cnt      = r_cnt;

endmodule : sb_entry

// File: rtl/id_scoreboard.sv
// Decode-stage register-hazard scoreboard: tracks a pending producer and its
// remaining latency per register, and drives the decode stall and the
// per-source forwarding selects.
module id_scoreboard
   import core_pkg::*;
#(
   parameter  int NREG  = NREG_DEF,
   parameter  int NRP   = 2,
   parameter  int NWB   = 1,
   parameter  int LAT_W = LAT_W_DEF,
   localparam int RW    = $clog2(NREG),
   localparam int CW    = $clog2(NREG + 1)
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              iss_valid,
   input  logic [NRP*RW-1:0] iss_src,
   input  logic [NRP-1:0]    iss_src_used,
   input  logic              iss_wr_en,
   input  logic [RW-1:0]     iss_wr_reg,
   input  logic [LAT_W-1:0]  iss_lat,
   input  logic              flush,
   input  logic [NWB-1:0]    wb_valid,
   input  logic [NWB*RW-1:0] wb_reg,
   output logic              stall,
   output logic [NRP-1:0]    src_fwd,
   output logic [NREG-1:0]   busy,
   output logic [CW-1:0]     pend_cnt
);

   logic [NREG-1:0]  w_pend;
   logic [NREG-1:0]  w_pend_nxt;
   logic [NREG-1:0]  w_wb_hit;
   logic [NREG-1:0]  w_pend_eff;
   logic [LAT_W-1:0] w_cnt [NREG];
   logic             w_blocked;
   logic             w_waw;
   logic             w_accept;
   logic [CW-1:0]    w_pop;
   logic [CW-1:0]    r_pend_cnt;

   // Decode write-back destinations into a per-register hit vector; several
   // ports naming the same register collapse into one clear.
   // NOTE: every variable driven here gets a default first so no latch is
   // inferred for the bits the loop does not touch.
   always_comb begin
      w_wb_hit = '0;
      for (int j = 0; j < NWB; j++) begin
         if (wb_valid[j]) w_wb_hit[wb_reg[j*RW +: RW]] = 1'b1;
      end
   end

   // A same-cycle write-back makes the register readable from the register file.
   assign w_pend_eff = w_pend & ~w_wb_hit;

   // Per-source hazard check: still counting means stall, counted out means forward.
   always_comb begin
      logic [RW-1:0] v_src;
      v_src     = '0;
      w_blocked = 1'b0;
      src_fwd   = '0;
      for (int k = 0; k < NRP; k++) begin
         v_src = iss_src[k*RW +: RW];
         if (iss_src_used[k] && (v_src != '0) && w_pend_eff[v_src]) begin
            if (w_cnt[v_src] != '0) w_blocked  = 1'b1;
            else                    src_fwd[k] = 1'b1;
         end
      end
      w_waw = iss_wr_en && w_pend_eff[iss_wr_reg] && (w_cnt[iss_wr_reg] != '0);
      stall = iss_valid && (w_blocked || w_waw);
   end

   assign w_accept = iss_valid & ~stall;

   // One entry per register; register 0 is hard-wired zero and never pending.
   for (genvar r = 0; r < NREG; r++) begin : g_entry
      if (r == 0) begin : g_zero
         assign w_pend[r]     = 1'b0;
         assign w_pend_nxt[r] = 1'b0;
         assign w_cnt[r]      = '0;
      end else begin : g_live
         sb_entry #(
            .LAT_W (LAT_W)
         ) u_entry (
            .Clk        (Clk),
            .Rst_n      (Rst_n),
            .i_flush    (flush),
            .i_load     (w_accept && iss_wr_en && (iss_wr_reg == RW'(r))),
            .i_lat      (iss_lat),
            .i_wb_hit   (w_wb_hit[r]),
            .o_pend     (w_pend[r]),
            .o_pend_nxt (w_pend_nxt[r]),
            .o_cnt      (w_cnt[r])
         );
      end
   end

   // Popcount of the next pending vector so the count lands with busy.
   always_comb begin
      w_pop = '0;
      for (int r = 0; r < NREG; r++) w_pop = w_pop + CW'(w_pend_nxt[r]);
   end

   // Pending-count register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_pend_cnt <= '0;
      else        r_pend_cnt <= w_pop;
   end

   assign busy     = w_pend;
   assign pend_cnt = r_pend_cnt;

endmodule : id_scoreboard

// File: tb/tb_id_scoreboard.sv
// Directed, table-driven bench for id_scoreboard with the default parameters.
module tb_id_scoreboard;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        iss_valid;
   logic [9:0]  iss_src;
   logic [1:0]  iss_src_used;
   logic        iss_wr_en;
   logic [4:0]  iss_wr_reg;
   logic [2:0]  iss_lat;
   logic        flush;
   logic [0:0]  wb_valid;
   logic [4:0]  wb_reg;
   logic        stall;
   logic [1:0]  src_fwd;
   logic [31:0] busy;
   logic [5:0]  pend_cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        v;
      logic [4:0]  s0;
      logic [4:0]  s1;
      logic [1:0]  used;
      logic        we;
      logic [4:0]  wr;
      logic [2:0]  lat;
      logic        fl;
      logic        wbv;
      logic [4:0]  wbr;
      logic        e_stall;
      logic [1:0]  e_fwd;
      logic [31:0] e_busy;
      logic [5:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   id_scoreboard u_dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .iss_valid    (iss_valid),
      .iss_src      (iss_src),
      .iss_src_used (iss_src_used),
      .iss_wr_en    (iss_wr_en),
      .iss_wr_reg   (iss_wr_reg),
      .iss_lat      (iss_lat),
      .flush        (flush),
      .wb_valid     (wb_valid),
      .wb_reg       (wb_reg),
      .stall        (stall),
      .src_fwd      (src_fwd),
      .busy         (busy),
      .pend_cnt     (pend_cnt)
   );

   always #5 Clk = ~Clk;

   function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                               input logic [1:0] used, input logic we, input logic [4:0] wr,
                               input logic [2:0] lat, input logic fl, input logic wbv,
                               input logic [4:0] wbr, input logic e_stall,
                               input logic [1:0] e_fwd, input logic [31:0] e_busy,
                               input logic [5:0] e_cnt);
      vec_t t;
      t.v = v; t.s0 = s0; t.s1 = s1; t.used = used; t.we = we; t.wr = wr; t.lat = lat;
      t.fl = fl; t.wbv = wbv; t.wbr = wbr;
      t.e_stall = e_stall; t.e_fwd = e_fwd; t.e_busy = e_busy; t.e_cnt = e_cnt;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      iss_valid    = t.v;
      iss_src      = {t.s1, t.s0};
      iss_src_used = t.used;
      iss_wr_en    = t.we;
      iss_wr_reg   = t.wr;
      iss_lat      = t.lat;
      flush        = t.fl;
      wb_valid     = t.wbv;
      wb_reg       = t.wbr;
   endtask

   task automatic check_outs(input string tag, input logic e_stall, input logic [1:0] e_fwd,
                             input logic [31:0] e_busy, input logic [5:0] e_cnt);
      check({tag, ".stall"},    32'(stall),    32'(e_stall));
      check({tag, ".src_fwd"},  32'(src_fwd),  32'(e_fwd));
      check({tag, ".busy"},     busy,          e_busy);
      check({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(e_cnt));
   endtask

   initial begin
      vec_t idle;
      idle = mk(0,0,0,2'b00,0,0,0,0,0,0, 0,2'b00,32'h0,0);

      //                v  s0 s1 used  we wr lat fl wbv wbr | stall fwd  busy  cnt
      // reset/idle
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 0, 0,    0,2'b00,32'h000,0));
      // r5 lat 2: two stall cycles (both ports), then forward, then write-back
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 5, 2, 0, 0, 0,    0,2'b00,32'h000,0));
      vecs.push_back(mk(1, 5, 0, 2'b01,0, 0, 0, 0, 0, 0,    1,2'b00,32'h020,1));
      vecs.push_back(mk(1, 0, 5, 2'b10,0, 0, 0, 0, 0, 0,    1,2'b00,32'h020,1));
      vecs.push_back(mk(1, 5, 0, 2'b01,0, 0, 0, 0, 0, 0,    0,2'b01,32'h020,1));
      vecs.push_back(mk(1, 5, 0, 2'b01,0, 0, 0, 0, 1, 5,    0,2'b00,32'h020,1));
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 0, 0,    0,2'b00,32'h000,0));
      // r7 lat 3, read together with write-back of r7: bypass
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 7, 3, 0, 0, 0,    0,2'b00,32'h000,0));
      vecs.push_back(mk(1, 7, 0, 2'b01,0, 0, 0, 0, 1, 7,    0,2'b00,32'h080,1));
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 0, 0,    0,2'b00,32'h000,0));
      // r9: re-issue with lat 1 during write-back of r9, new producer wins
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 9, 3, 0, 0, 0,    0,2'b00,32'h000,0));
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 9, 1, 0, 1, 9,    0,2'b00,32'h200,1));
      vecs.push_back(mk(1, 9, 0, 2'b01,0, 0, 0, 0, 0, 0,    1,2'b00,32'h200,1));
      vecs.push_back(mk(1, 9, 0, 2'b01,0, 0, 0, 0, 0, 0,    0,2'b01,32'h200,1));
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 1, 9,    0,2'b00,32'h200,1));
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 0, 0,    0,2'b00,32'h000,0));
      // WAW on r3, then writes/reads of r0, idle read, stray write-back
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 3, 2, 0, 0, 0,    0,2'b00,32'h000,0));
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 3, 5, 0, 0, 0,    1,2'b00,32'h008,1));
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 3, 5, 0, 0, 0,    1,2'b00,32'h008,1));
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 3, 5, 0, 0, 0,    0,2'b00,32'h008,1));
      vecs.push_back(mk(1, 0, 0, 2'b10,1, 0, 4, 0, 0, 0,    0,2'b00,32'h008,1));
      vecs.push_back(mk(0, 3, 0, 2'b01,0, 0, 0, 0, 0, 0,    0,2'b00,32'h008,1));
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 1,12,    0,2'b00,32'h008,1));
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 1, 3,    0,2'b00,32'h008,1));
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 0, 0,    0,2'b00,32'h000,0));
      // four producers, then flush together with an accept
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 1, 4, 0, 0, 0,    0,2'b00,32'h000,0));
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 2, 4, 0, 0, 0,    0,2'b00,32'h002,1));
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 4, 4, 0, 0, 0,    0,2'b00,32'h006,2));
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 6, 4, 0, 0, 0,    0,2'b00,32'h016,3));
      vecs.push_back(mk(1, 0, 0, 2'b00,1, 8, 2, 1, 0, 0,    0,2'b00,32'h056,4));
      vecs.push_back(mk(0, 0, 0, 2'b00,0, 0, 0, 0, 0, 0,    0,2'b00,32'h000,0));

      Rst_n = 1'b0;
      drive(idle);
      #1;
      check_outs("in_reset", 1'b0, 2'b00, 32'h0, 6'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #1;
         check_outs($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_fwd,
                    vecs[i].e_busy, vecs[i].e_cnt);
         @(negedge Clk);
      end

      // Zero-latency producer on r11 next to a long one on r10.
      drive(mk(1, 0, 0, 2'b00, 1, 10, 5, 0, 0, 0, 0, 2'b00, 32'h0, 0));
      @(negedge Clk);
      drive(mk(1, 0, 0, 2'b00, 1, 11, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0));
      @(negedge Clk);
      drive(mk(1, 11, 10, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0));
      #1;
      check_outs("lat0_mix", 1'b1, 2'b01, 32'h0000_0c00, 6'd2);

      // Asynchronous reset in the middle of the countdown, well before the edge.
      #2;
      Rst_n = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, 2'b00, 32'h0, 6'd0);
      @(negedge Clk);
      drive(idle);
      Rst_n = 1'b1;
      @(negedge Clk);
      check_outs("post_rst", 1'b0, 2'b00, 32'h0, 6'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_id_scoreboard
